// File: rtl/hamming_secded_codec.sv
// Streaming Hamming SECDED encoder/decoder with a two-stage valid/ready pipeline
// and saturating single/double error counters.
module hamming_secded_codec #(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 8,
    localparam int CW_W  = DATA_W + PAR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_data,
    output logic [1:0]       out_status,
    output logic [PAR_W-1:0] out_err_pos,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    function automatic bit is_pow2(input int p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // Codeword index holding data bit idx (0-based).
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < CW_W; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Data bit number (0-based) stored at codeword index p.
    function automatic int data_idx(input int p);
        int cnt;
        cnt = 0;
        for (int q = 1; q < p; q++) begin
            if (!is_pow2(q)) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [PAR_W-1:0] syndrome(input logic [CW_W-1:0] cw);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (cw[p]) s ^= PAR_W'(p);
        end
        return s;
    endfunction

    logic [CW_W-1:0]  scat;
    logic [CW_W-1:0]  pre_cw;
    logic [PAR_W-1:0] pre_syn;
    logic             pre_ov;

    logic             s1_valid_reg;
    logic             s1_mode_reg;
    logic [CW_W-1:0]  s1_cw_reg;
    logic [PAR_W-1:0] s1_syn_reg;
    logic             s1_ov_reg;

    logic             out_valid_reg;
    logic [CW_W-1:0]  out_data_reg;
    logic [1:0]       out_status_reg;
    logic [PAR_W-1:0] out_err_pos_reg;
    logic [CNT_W-1:0] cnt_single_reg;
    logic [CNT_W-1:0] cnt_double_reg;

    logic [CW_W-1:0]  enc_cw;
    logic [CW_W-1:0]  cor_cw;
    logic [DATA_W-1:0] dec_msg;
    logic [1:0]       dec_status;
    logic [PAR_W-1:0] dec_pos;

    logic [CW_W-1:0]  out_data_next;
    logic [1:0]       out_status_next;
    logic [PAR_W-1:0] out_err_pos_next;
    logic [CNT_W-1:0] cnt_single_next;
    logic [CNT_W-1:0] cnt_double_next;

    logic s2_adv;
    logic out_xfer;

    assign s2_adv   = !out_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign out_xfer = out_valid_reg && out_ready;

    // Message bits scattered to their codeword slots, parity slots left at zero.
    for (genvar gi = 0; gi < CW_W; gi++) begin : g_scatter
        if (gi != 0 && !is_pow2(gi)) begin : g_data
            localparam int DI = data_idx(gi);
            assign scat[gi] = in_data[DI];
        end else begin : g_par
            assign scat[gi] = 1'b0;
        end
    end

    // With parity slots zeroed, the syndrome of the scattered word is exactly
    // the parity vector, so one syndrome tree serves both modes.
    assign pre_cw  = mode ? in_data : scat;
    assign pre_syn = syndrome(pre_cw);
    assign pre_ov  = ^pre_cw;

    always_comb begin
        enc_cw = s1_cw_reg;
        for (int k = 0; k < PAR_W; k++) begin
            enc_cw[1 << k] = s1_syn_reg[k];
        end
        enc_cw[0] = s1_ov_reg ^ (^s1_syn_reg);
    end

    always_comb begin
        cor_cw     = s1_cw_reg;
        dec_status = 2'b00;
        dec_pos    = '0;
        if (s1_ov_reg) begin
            if (s1_syn_reg == '0) begin
                dec_status = 2'b01;
            end else if (int'(s1_syn_reg) < CW_W) begin
                dec_status = 2'b01;
                dec_pos    = s1_syn_reg;
                cor_cw     = s1_cw_reg ^ (CW_W'(1) << s1_syn_reg);
            end else begin
                dec_status = 2'b10;
            end
        end else if (s1_syn_reg != '0) begin
            dec_status = 2'b10;
        end
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_gather
        localparam int DP = data_pos(gi);
        assign dec_msg[gi] = cor_cw[DP];
    end

    always_comb begin
        out_data_next    = enc_cw;
        out_status_next  = 2'b00;
        out_err_pos_next = '0;
        if (s1_mode_reg) begin
            out_data_next    = CW_W'(dec_msg);
            out_status_next  = dec_status;
            out_err_pos_next = dec_pos;
        end
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        cnt_single_next = cnt_single_reg;
        cnt_double_next = cnt_double_reg;
        if (clr_cnt) begin
            cnt_single_next = '0;
            cnt_double_next = '0;
        end else if (out_xfer) begin
            if (out_status_reg == 2'b01 && cnt_single_reg != '1)
                cnt_single_next = cnt_single_reg + 1'b1;
            if (out_status_reg == 2'b10 && cnt_double_reg != '1)
                cnt_double_next = cnt_double_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg    <= 1'b0;
            s1_mode_reg     <= 1'b0;
            s1_cw_reg       <= '0;
            s1_syn_reg      <= '0;
            s1_ov_reg       <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_status_reg  <= 2'b00;
            out_err_pos_reg <= '0;
            cnt_single_reg  <= '0;
            cnt_double_reg  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_mode_reg <= mode;
                    s1_cw_reg   <= pre_cw;
                    s1_syn_reg  <= pre_syn;
                    s1_ov_reg   <= pre_ov;
                end
            end
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg    <= out_data_next;
                    out_status_reg  <= out_status_next;
                    out_err_pos_reg <= out_err_pos_next;
                end
            end
            cnt_single_reg <= cnt_single_next;
            cnt_double_reg <= cnt_double_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_status  = out_status_reg;
    assign out_err_pos = out_err_pos_reg;
    assign cnt_single  = cnt_single_reg;
    assign cnt_double  = cnt_double_reg;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec: encode/decode vectors, backpressure,
// counter saturation and clear priority, and mid-stream reset.
module tb_hamming_secded_codec;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_status;
    logic [3:0]  out_err_pos;
    logic        clr_cnt;
    logic [7:0]  cnt_single;
    logic [7:0]  cnt_double;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [15:0] out_data_b;
    logic [1:0]  out_status_b;
    logic [3:0]  out_err_pos_b;
    logic [1:0]  cnt_single_b;
    logic [1:0]  cnt_double_b;

    int n_checks = 0;
    int n_errors = 0;

    hamming_secded_codec dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_status(out_status), .out_err_pos(out_err_pos), .clr_cnt(clr_cnt),
        .cnt_single(cnt_single), .cnt_double(cnt_double)
    );

    hamming_secded_codec #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_status(out_status_b), .out_err_pos(out_err_pos_b), .clr_cnt(clr_cnt),
        .cnt_single(cnt_single_b), .cnt_double(cnt_double_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word with no backpressure: accept edge, one pipeline edge, then output.
    task automatic run_word(input string tag, input logic m, input logic [15:0] din,
                            input logic [15:0] ed, input logic [1:0] es, input logic [3:0] ep);
        @(negedge clk);
        mode = m; in_data = din; in_valid = 1'b1; out_ready = 1'b1;
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        $display("word %s mode=%0d in=%h out=%h status=%0d pos=%0d", tag, m, din, out_data, out_status, out_err_pos);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_data"}, 32'(out_data), 32'(ed));
        check_val({tag, "_status"}, 32'(out_status), 32'(es));
        check_val({tag, "_pos"}, 32'(out_err_pos), 32'(ep));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_cnt = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_status", 32'(out_status), 32'd0);
        check_val("rst_cnt_s", 32'(cnt_single), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);

        run_word("enc_555", 1'b0, 16'h0555, 16'hAA5A, 2'b00, 4'd0);
        run_word("enc_000", 1'b0, 16'h0000, 16'h0000, 2'b00, 4'd0);
        run_word("enc_7ff", 1'b0, 16'h07FF, 16'hFFFF, 2'b00, 4'd0);
        run_word("dec_clean", 1'b1, 16'hAA5A, 16'h0555, 2'b00, 4'd0);
        run_word("dec_bit6", 1'b1, 16'hAA1A, 16'h0555, 2'b01, 4'd6);
        check_val("cnt_s_1", 32'(cnt_single), 32'd1);
        run_word("dec_p0", 1'b1, 16'hAA5B, 16'h0555, 2'b01, 4'd0);
        run_word("dec_dbl", 1'b1, 16'hA81A, 16'h0541, 2'b10, 4'd0);
        check_val("cnt_d_1", 32'(cnt_double), 32'd1);
        check_val("cnt_s_2", 32'(cnt_single), 32'd2);
        run_word("dec_bit12", 1'b1, 16'hEFFF, 16'h07FF, 2'b01, 4'd12);
        run_word("dec_p0_only", 1'b1, 16'h0001, 16'h0000, 2'b01, 4'd0);
        check_val("cnt_s_4", 32'(cnt_single), 32'd4);
        check_val("cnt_s_sat_early", 32'(cnt_single_b), 32'd3);

        // Backpressure: three words offered while the sink stalls.
        @(negedge clk);
        out_ready = 1'b0; mode = 1'b1; in_data = 16'hAA5A; in_valid = 1'b1;
        check_val("bp_rdy0", 32'(in_ready), 32'd1);
        @(negedge clk);
        mode = 1'b1; in_data = 16'hFFFF;
        check_val("bp_rdy1", 32'(in_ready), 32'd1);
        @(negedge clk);
        mode = 1'b0; in_data = 16'h0555;
        check_val("bp_rdy2", 32'(in_ready), 32'd0);
        check_val("bp_hold_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_stall_rdy", 32'(in_ready), 32'd0);
            check_val("bp_hold_data", 32'(out_data), 32'h0555);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("word bp1 out=%h", out_data);
        check_val("bp_out1_valid", 32'(out_valid), 32'd1);
        check_val("bp_out1_data", 32'(out_data), 32'h07FF);
        @(negedge clk);
        $display("word bp2 out=%h", out_data);
        check_val("bp_out2_valid", 32'(out_valid), 32'd1);
        check_val("bp_out2_data", 32'(out_data), 32'hAA5A);
        @(negedge clk);
        check_val("bp_drained", 32'(out_valid), 32'd0);

        // Clear, then five back-to-back single-error words.
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check_val("clr_cnt_s", 32'(cnt_single), 32'd0);
        check_val("clr_cnt_s_b", 32'(cnt_single_b), 32'd0);
        mode = 1'b1; in_data = 16'hAA1A; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("burst of 5 single-error words: cnt=%0d cnt_w2=%0d", cnt_single, cnt_single_b);
        check_val("burst_cnt_s", 32'(cnt_single), 32'd5);
        check_val("sat_cnt_s", 32'(cnt_single_b), 32'd3);
        check_val("burst_cnt_d", 32'(cnt_double), 32'd0);

        // Clear landing on the same edge as a single-error transfer.
        mode = 1'b1; in_data = 16'hAA1A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("clr_coinc_valid", 32'(out_valid), 32'd1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        $display("clear coincident with increment: cnt=%0d", cnt_single);
        check_val("clr_wins", 32'(cnt_single), 32'd0);
        check_val("clr_wins_b", 32'(cnt_single_b), 32'd0);

        run_word("dec_dbl2", 1'b1, 16'hA81A, 16'h0541, 2'b10, 4'd0);
        check_val("cnt_d_pre_rst", 32'(cnt_double), 32'd1);

        // Reset with two words in flight.
        @(negedge clk);
        out_ready = 1'b0; mode = 1'b1; in_data = 16'hAA1A; in_valid = 1'b1;
        @(negedge clk);
        mode = 1'b0; in_data = 16'h07FF;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("inflight_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_val("mrst_valid", 32'(out_valid), 32'd0);
        check_val("mrst_data", 32'(out_data), 32'd0);
        check_val("mrst_status", 32'(out_status), 32'd0);
        check_val("mrst_pos", 32'(out_err_pos), 32'd0);
        check_val("mrst_cnt_d", 32'(cnt_double), 32'd0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        check_val("post_rst_ready", 32'(in_ready), 32'd1);
        check_val("post_rst_cnt_s", 32'(cnt_single), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
